// File: rtl/bht_port_scheduler.sv
// Single-port arbiter for a 32x2 branch history table: clears the table after reset/flush,
// then shares the port between fetch lookups and queued read-modify-write counter updates.
module bht_port_scheduler #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic       clk,
  input  logic       arst,
  input  logic       flush,
  input  logic       lookup_valid,
  output logic       lookup_ready,
  input  logic [4:0] lookup_addr,
  output logic       pred_valid,
  output logic       pred_taken,
  input  logic       upd_valid,
  output logic       upd_ready,
  input  logic [4:0] upd_addr,
  input  logic       upd_taken,
  output logic [4:0] tbl_addr,
  output logic       tbl_we,
  output logic [1:0] tbl_wdata,
  input  logic [1:0] tbl_rdata,
  output logic       busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  localparam logic [1:0] S_INIT   = 2'd0;
  localparam logic [1:0] S_IDLE   = 2'd1;
  localparam logic [1:0] S_UPD_WR = 2'd2;

  logic [1:0]                 r_state;
  logic [4:0]                 r_sweep;
  logic [FIFO_DEPTH-1:0][4:0] r_fifo_addr;
  logic [FIFO_DEPTH-1:0]      r_fifo_taken;
  logic [AW:0]                r_wptr;
  logic [AW:0]                r_rptr;
  logic [SW-1:0]              r_starve;
  logic                       r_pred_valid;

  logic       w_empty;
  logic       w_full;
  logic [4:0] w_head_addr;
  logic       w_head_taken;
  logic       w_idle;
  logic       w_grant_upd;
  logic       w_grant_lk;
  logic       w_wr;
  logic       w_sweep_wr;
  logic       w_push;
  logic [1:0] w_next_ctr;

  assign w_empty      = (r_wptr == r_rptr);
  assign w_full       = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_head_addr  = r_fifo_addr[r_rptr[AW-1:0]];
  assign w_head_taken = r_fifo_taken[r_rptr[AW-1:0]];

  // flush and reset both silence the port in the current cycle
  assign w_idle      = (r_state == S_IDLE) && !flush && !arst;
  assign w_grant_upd = w_idle && !w_empty && (!lookup_valid || (r_starve == STARVE_MAX));
  assign w_grant_lk  = w_idle && lookup_valid && !w_grant_upd;
  assign w_wr        = (r_state == S_UPD_WR) && !flush && !arst;
  assign w_sweep_wr  = (r_state == S_INIT) && !flush && !arst;

  assign upd_ready = !w_full && !arst;
  assign w_push    = upd_valid && upd_ready && !flush;

  always_comb begin
    w_next_ctr = tbl_rdata;
    if (w_head_taken) begin
      if (tbl_rdata != 2'b11) w_next_ctr = tbl_rdata + 2'd1;
    end else begin
      if (tbl_rdata != 2'b00) w_next_ctr = tbl_rdata - 2'd1;
    end
  end

  always_comb begin
    lookup_ready = w_grant_lk;
    tbl_we       = w_sweep_wr || w_wr;
    tbl_addr     = '0;
    tbl_wdata    = '0;
    if (w_sweep_wr)                tbl_addr = r_sweep;
    else if (w_grant_lk)           tbl_addr = lookup_addr;
    else if (w_grant_upd || w_wr)  tbl_addr = w_head_addr;
    if (w_wr) tbl_wdata = w_next_ctr;
  end

  assign busy       = (r_state == S_INIT);
  assign pred_valid = r_pred_valid;
  assign pred_taken = r_pred_valid & tbl_rdata[1];

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state      <= S_INIT;
      r_sweep      <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_starve     <= '0;
      r_pred_valid <= 1'b0;
    end else begin
      // a lookup granted just before a flush still gets its result
      r_pred_valid <= w_grant_lk;
      if (flush) begin
        r_state  <= S_INIT;
        r_sweep  <= '0;
        r_wptr   <= '0;
        r_rptr   <= '0;
        r_starve <= '0;
      end else begin
        case (r_state)
          S_INIT: begin
            r_sweep <= r_sweep + 5'd1;
            if (r_sweep == 5'd31) r_state <= S_IDLE;
          end
          S_IDLE:   if (w_grant_upd) r_state <= S_UPD_WR;
          S_UPD_WR: r_state <= S_IDLE;
          default:  r_state <= S_INIT;
        endcase
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_wr)   r_rptr <= r_rptr + 1'b1;
        if (w_grant_upd || w_empty)
          r_starve <= '0;
        else if (w_grant_lk && (r_starve != STARVE_MAX))
          r_starve <= r_starve + SW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wptr[AW-1:0]]  <= upd_addr;
      r_fifo_taken[r_wptr[AW-1:0]] <= upd_taken;
    end
  end

endmodule

// File: doc/bht_port_scheduler.md
BHT_PORT_SCHEDULER -- requirements
Module: bht_port_scheduler

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the number of pending-update entries (power of two, >=2).
REQ-002 Parameter STARVE_LIMIT, default 3, SHALL set how many consecutive lookup grants are allowed while updates wait.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 arst  input  1  reset, asynchronous, active-high.
REQ-005 flush  input  1  one-cycle pulse: drop pending updates and re-clear the table.
REQ-006 lookup_valid / lookup_ready  input / output  1 / 1  fetch-side prediction request handshake.
REQ-007 lookup_addr  input  5  table index for the lookup.
REQ-008 pred_valid / pred_taken  output / output  1 / 1  prediction result for an accepted lookup.
REQ-009 upd_valid / upd_ready  input / output  1 / 1  execute-side resolved-branch handshake.
REQ-010 upd_addr / upd_taken  input / input  5 / 1  index and outcome of the resolved branch.
REQ-011 tbl_addr / tbl_we / tbl_wdata  output / output / output  5 / 1 / 2  single port to the 32x2 counter table.
REQ-012 tbl_rdata  input  2  table read data, valid one cycle after a read access (tbl_we=0).
REQ-013 busy  output  1  high while the clear sweep runs.

Function
REQ-014 The block SHALL use FSM states INIT, IDLE and UPD_WR, and SHALL perform at most one table access per cycle.
REQ-015 INIT: drive tbl_we=1, tbl_wdata=2'b00, tbl_addr=sweep index 0..31 (one per cycle), busy=1, lookup_ready=0; after index 31 go to IDLE (32 cycles total).
REQ-016 Update FIFO: upd_ready = !full; push on upd_valid&&upd_ready; no bypass, so upd_ready=0 when full even if a pop occurs the same cycle; upd_ready is allowed to be 1 during INIT.
REQ-017 IDLE arbitration: if FIFO is non-empty and (lookup_valid=0 or starve count == STARVE_LIMIT), grant the update; else if lookup_valid, grant the lookup.
REQ-018 Lookup grant: lookup_ready=1, tbl_we=0, tbl_addr=lookup_addr; next cycle pred_valid=1 and pred_taken=tbl_rdata[1]; otherwise pred_valid=0.
REQ-019 Starve count: +1 (saturating at STARVE_LIMIT) on each lookup grant while FIFO is non-empty; cleared on each update grant and whenever FIFO is empty.
REQ-020 Update grant (IDLE): lookup_ready=0, tbl_we=0, tbl_addr=FIFO head addr; go to UPD_WR.
REQ-021 UPD_WR: lookup_ready=0, tbl_we=1, tbl_addr=head addr, tbl_wdata=saturating next of tbl_rdata (taken: +1, capped at 2'b11; not taken: -1, floored at 2'b00); pop head; return to IDLE.
REQ-022 No forwarding: a lookup to an index with a queued update SHALL read the current table value.
REQ-023 Back-to-back updates SHALL take 2 cycles each; port utilisation SHALL be 100 % when requests are continuous.
REQ-024 flush (any state) SHALL, in that cycle, force lookup_ready=0 and tbl_we=0, and on the next edge empty the FIFO, zero the starve count, and enter INIT at index 0. A write pending in UPD_WR is abandoned.
REQ-025 A flush during INIT SHALL restart the sweep at index 0.
REQ-026 A lookup accepted the cycle before a flush SHALL still produce its pred_valid pulse.
REQ-027 An update push coincident with flush SHALL be discarded.

Reset
REQ-028 While arst=1: state=INIT, sweep index=0, FIFO empty, starve count=0, pred_valid=0, pred_taken=0, lookup_ready=0, tbl_we=0, tbl_addr=0, tbl_wdata=0, busy=1, upd_ready=0.
REQ-029 After arst deasserts, the sweep SHALL start on the first rising edge; busy SHALL fall after 32 write cycles.
REQ-030 Assertion of arst mid-sweep or mid-update SHALL return all state to REQ-028 values immediately.

Verification
REQ-031 Reset release -> tbl_we=1 for exactly 32 cycles, addr 0..31, wdata 00, then busy=0 and lookup_ready follows lookup_valid.
REQ-032 Three updates, idx 5, taken, FIFO drained, then lookup idx 5 -> reads observe 00,01,10; writes 01,10,11; pred_taken=1 one cycle after accept.
REQ-033 Continuous lookup_valid with 1 queued update, STARVE_LIMIT=3 -> 3 lookup grants, then update read+write (lookup_ready=0 for 2 cycles), then lookups resume.
REQ-034 Push 5 updates with no lookups stalled (hold in INIT) -> upd_ready=0 after 4 accepted; 5th accepted only after the first pop.
REQ-035 flush asserted in UPD_WR with 2 queued entries -> no write that cycle, FIFO empty, 32-cycle sweep restarts at index 0.
REQ-036 Counter saturation: idx 9 at 11 with taken -> writes 11; at 00 with not taken -> writes 00.
